// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 FFT address generation path.
package fft_pkg;

    localparam int unsigned LOG2N_MAX = 10;
    localparam int unsigned ROT_W     = 2 * LOG2N_MAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Rotate 'value' left by 'shift' within the low 'len' bits.
    // Caller guarantees value < 2**len and shift < len.
    function automatic logic [LOG2N_MAX-1:0] rotl_l(
        input logic [LOG2N_MAX-1:0] value,
        input int unsigned          shift,
        input int unsigned          len
    );
        logic [ROT_W-1:0] wide;
        logic [ROT_W-1:0] mask;
        wide   = ROT_W'(value) << shift;
        mask   = (ROT_W'(1) << len) - ROT_W'(1);
        rotl_l = LOG2N_MAX'((wide & mask) | (wide >> len));
    endfunction

endpackage

// File: rtl/fft_agu_addr_map.sv
// Combinational butterfly address and twiddle mapping for (j, s, L).
module fft_agu_addr_map
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N = 10
) (
    input  logic [LOG2N-2:0]             j,
    input  logic [$clog2(LOG2N)-1:0]     s,
    input  logic [$clog2(LOG2N+1)-1:0]   len,
    output logic [LOG2N-1:0]             address_a,
    output logic [LOG2N-1:0]             address_b,
    output logic [LOG2N-2:0]             twiddle
);

    int unsigned shift_r;
    int unsigned shift_l;

    // Leg addresses are {j,leg} rotated by the stage; twiddle stride is tied to LOG2N, not L.
    always_comb begin
        shift_r   = 32'(len) - 32'(s) - 32'd1;
        shift_l   = LOG2N - 32'd1 - 32'(s);
        address_a = LOG2N'(rotl_l(LOG2N_MAX'({j, 1'b0}), 32'(s), 32'(len)));
        address_b = LOG2N'(rotl_l(LOG2N_MAX'({j, 1'b1}), 32'(s), 32'(len)));
        twiddle   = (LOG2N-1)'((j >> shift_r) << shift_l);
    end

endmodule

// File: rtl/fft_agu_param.sv
// Runtime-length radix-2 FFT address generator with valid/ready stall handshake.
module fft_agu_param
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N     = 10,
    parameter int unsigned MIN_LOG2N = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic [$clog2(LOG2N+1)-1:0]     cfg_log2n_i,
    input  logic                           ready_i,
    output logic                           valid_o,
    output logic [LOG2N-1:0]               address_a_o,
    output logic [LOG2N-1:0]               address_b_o,
    output logic [LOG2N-2:0]               twiddle_addr_o,
    output logic                           memsel_o,
    output logic [$clog2(LOG2N)-1:0]       stage_o,
    output logic                           last_stage_o,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int unsigned LW = $clog2(LOG2N + 1);
    localparam int unsigned SW = $clog2(LOG2N);
    localparam int unsigned JW = LOG2N - 1;

    state_t          state, state_n;
    logic [JW-1:0]   j, j_n, j_last;
    logic [SW-1:0]   s, s_n;
    logic [LW-1:0]   len, len_n;
    logic            s_last;
    logic            valid_n, busy_n, done_n, last_n;
    logic [LOG2N-1:0] map_a, map_b;
    logic [JW-1:0]   map_tw;

    // Outputs are computed from the next counter values so they line up with the registered counters.
    fft_agu_addr_map #(.LOG2N(LOG2N)) u_addr_map (
        .j         (j_n),
        .s         (s_n),
        .len       (len_n),
        .address_a (map_a),
        .address_b (map_b),
        .twiddle   (map_tw)
    );

    // Next-state, counter advance and next-output decode.
    always_comb begin
        state_n = state;
        j_n     = j;
        s_n     = s;
        len_n   = len;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        j_last  = JW'((32'd1 << (32'(len) - 32'd1)) - 32'd1);
        s_last  = (32'(s) == 32'(len) - 32'd1);

        case (state)
            IDLE: begin
                if (start_i) begin
                    if (cfg_log2n_i < LW'(MIN_LOG2N))
                        len_n = LW'(MIN_LOG2N);
                    else if (cfg_log2n_i > LW'(LOG2N))
                        len_n = LW'(LOG2N);
                    else
                        len_n = cfg_log2n_i;
                    j_n     = '0;
                    s_n     = '0;
                    state_n = RUN;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            RUN: begin
                valid_n = 1'b1;
                busy_n  = 1'b1;
                if (ready_i) begin
                    if (j == j_last) begin
                        j_n = '0;
                        if (s_last) begin
                            state_n = DONE;
                            valid_n = 1'b0;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            s_n = s + SW'(1);
                        end
                    end else begin
                        j_n = j + JW'(1);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        last_n = valid_n && (32'(s_n) == 32'(len_n) - 32'd1);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            j              <= '0;
            s              <= '0;
            len            <= LW'(LOG2N);
            valid_o        <= 1'b0;
            address_a_o    <= '0;
            address_b_o    <= '0;
            twiddle_addr_o <= '0;
            memsel_o       <= 1'b0;
            stage_o        <= '0;
            last_stage_o   <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            state          <= state_n;
            j              <= j_n;
            s              <= s_n;
            len            <= len_n;
            valid_o        <= valid_n;
            address_a_o    <= valid_n ? map_a  : '0;
            address_b_o    <= valid_n ? map_b  : '0;
            twiddle_addr_o <= valid_n ? map_tw : '0;
            memsel_o       <= valid_n & s_n[0];
            stage_o        <= valid_n ? s_n : '0;
            last_stage_o   <= last_n;
            busy_o         <= busy_n;
            done_o         <= done_n;
        end
    end

endmodule

// File: tb/tb_fft_agu_param.sv
// Scoreboard bench for fft_agu_param at LOG2N=4 with randomized stalls and start noise.
module tb_fft_agu_param;

    localparam int LOG2N = 4;
    localparam int MINL  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [2:0] cfg_log2n_i;
    logic       ready_i;
    logic       valid_o;
    logic [3:0] address_a_o, address_b_o;
    logic [2:0] twiddle_addr_o;
    logic       memsel_o;
    logic [1:0] stage_o;
    logic       last_stage_o, busy_o, done_o;

    fft_agu_param #(.LOG2N(LOG2N), .MIN_LOG2N(MINL)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .cfg_log2n_i    (cfg_log2n_i),
        .ready_i        (ready_i),
        .valid_o        (valid_o),
        .address_a_o    (address_a_o),
        .address_b_o    (address_b_o),
        .twiddle_addr_o (twiddle_addr_o),
        .memsel_o       (memsel_o),
        .stage_o        (stage_o),
        .last_stage_o   (last_stage_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       dn;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] tw;
        logic       ms;
        logic [1:0] st;
        logic       last;
    } item_t;

    item_t exp_q[$];
    item_t log_q[$];
    int    vectors = 0;
    int    errors  = 0;
    int    cyc     = 0;
    int    acc_cnt = 0;
    int    done_cnt = 0;
    int    runs    = 0;
    int    first_valid_cyc = 0;
    int    done_cyc = 0;
    logic  stall_mode = 1'b0;
    logic  prev_valid = 1'b0;
    logic  prev_stalled = 1'b0;
    item_t snap;

    always @(posedge clk) cyc <= cyc + 1;

    // Ready is either held high or randomly dropped about a quarter of the time.
    always @(posedge clk) begin
        #1;
        ready_i = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    function automatic int clampl(int c);
        if (c < MINL)  return MINL;
        if (c > LOG2N) return LOG2N;
        return c;
    endfunction

    function automatic item_t mk(int a, int b, int tw, int ms, int st, int last);
        item_t it;
        it.dn = 1'b0; it.a = 4'(a); it.b = 4'(b); it.tw = 3'(tw);
        it.ms = 1'(ms); it.st = 2'(st); it.last = 1'(last);
        return it;
    endfunction

    // Reference butterfly: bit i of {j,leg} moves to bit (i+s) mod L.
    function automatic item_t model(int L, int s, int j);
        int xa, xb, ra, rb, tw;
        xa = 2 * j;
        xb = 2 * j + 1;
        ra = 0;
        rb = 0;
        for (int i = 0; i < L; i++) begin
            if (((xa >> i) & 1) != 0) ra += 1 << ((i + s) % L);
            if (((xb >> i) & 1) != 0) rb += 1 << ((i + s) % L);
        end
        tw = (j >> (L - 1 - s)) << (LOG2N - 1 - s);
        return mk(ra, rb, tw, s % 2, s, (s == L - 1) ? 1 : 0);
    endfunction

    task automatic check(string name, int got, int expv);
        vectors++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic check_item(string name, item_t got, item_t expv);
        vectors++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, expv, $time);
        end
    endtask

    task automatic fail_now(string name);
        vectors++;
        errors++;
        $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
    endtask

    // Monitor: pops expected butterflies on accept, expected done markers on done_o, checks stall hold.
    always @(negedge clk) begin : monitor
        item_t cur, e;
        if (!rst) begin
            cur = mk(address_a_o, address_b_o, twiddle_addr_o, memsel_o, stage_o, last_stage_o);
            if (prev_stalled) check_item("stall_hold", cur, snap);
            if (valid_o && !prev_valid) first_valid_cyc = cyc;
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) fail_now("unexpected_accept");
                else begin
                    e = exp_q.pop_front();
                    check_item("butterfly", cur, e);
                end
                log_q.push_back(cur);
                acc_cnt++;
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                if (exp_q.size() == 0) fail_now("unexpected_done");
                else begin
                    e = exp_q.pop_front();
                    check("done_marker", int'(e.dn), 1);
                end
            end
            prev_stalled = valid_o && !ready_i;
            snap         = cur;
            prev_valid   = valid_o;
        end else begin
            prev_stalled = 1'b0;
            prev_valid   = 1'b0;
        end
    end

    task automatic push_expect(int cfg);
        int L;
        item_t mark;
        L = clampl(cfg);
        for (int s = 0; s < L; s++)
            for (int j = 0; j < (1 << (L - 1)); j++)
                exp_q.push_back(model(L, s, j));
        mark = '0;
        mark.dn = 1'b1;
        exp_q.push_back(mark);
    endtask

    task automatic pulse_start(int cfg);
        @(posedge clk); #1;
        start_i     = 1'b1;
        cfg_log2n_i = 3'(cfg);
        @(posedge clk); #1;
        start_i     = 1'b0;
        cfg_log2n_i = 3'($urandom);
        check("first_valid", int'(valid_o), 1);
        check("busy_running", int'(busy_o), 1);
    endtask

    task automatic run(int cfg, bit stalls, bit noise);
        int  L, n, d0;
        bit  got;
        L   = clampl(cfg);
        n   = L * (1 << (L - 1));
        d0  = done_cnt;
        got = 1'b0;
        stall_mode = stalls;
        exp_q.delete();
        log_q.delete();
        acc_cnt = 0;
        push_expect(cfg);
        pulse_start(cfg);
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (done_o) begin
                got = 1'b1;
                check("done_cycle_idle", int'({valid_o, busy_o}), 0);
                start_i     = noise;
                cfg_log2n_i = 3'($urandom);
                break;
            end
            start_i     = noise && ($urandom_range(0, 5) == 0);
            cfg_log2n_i = 3'($urandom);
        end
        if (!got) fail_now("done_timeout");
        @(posedge clk); #1;
        start_i = 1'b0;
        check("idle_after_done", int'({valid_o, busy_o, done_o}), 0);
        check("accept_count", acc_cnt, n);
        check("single_done", done_cnt - d0, 1);
        if (!stalls) check("done_latency", done_cyc - first_valid_cyc, n);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        runs++;
        stall_mode = 1'b0;
    endtask

    task automatic reset_mid_run();
        int d0;
        bit got;
        got = 1'b0;
        stall_mode = 1'b1;
        exp_q.delete();
        push_expect(4);
        pulse_start(4);
        for (int k = 0; k < 500; k++) begin
            @(posedge clk); #1;
            if (valid_o && stage_o == 2'd2) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("reach_stage2_timeout");
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs",
              int'({valid_o, address_a_o, address_b_o, twiddle_addr_o, memsel_o,
                    stage_o, last_stage_o, busy_o, done_o}), 0);
        exp_q.delete();
        d0 = done_cnt;
        stall_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("no_done_after_reset", done_cnt - d0, 0);
        check("idle_after_reset", int'({valid_o, busy_o}), 0);
    endtask

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        cfg_log2n_i = '0;
        ready_i     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              int'({valid_o, address_a_o, address_b_o, twiddle_addr_o, memsel_o,
                    stage_o, last_stage_o, busy_o, done_o}), 0);
        rst = 1'b0;

        run(4, 1'b0, 1'b0);
        if (log_q.size() > 27) begin
            check_item("l4_s0_j0", log_q[0],  mk(0, 1, 0, 0, 0, 0));
            check_item("l4_s1_j5", log_q[13], mk(5, 7, 4, 1, 1, 0));
            check_item("l4_s3_j3", log_q[27], mk(3, 11, 3, 1, 3, 1));
        end else fail_now("l4_log_short");

        run(3, 1'b0, 1'b0);
        if (log_q.size() > 11) check_item("l3_s2_j3", log_q[11], mk(3, 7, 6, 0, 2, 1));
        else fail_now("l3_log_short");

        run(4, 1'b1, 1'b0);
        run(3, 1'b1, 1'b0);
        run(4, 1'b0, 1'b1);
        run(0, 1'b0, 1'b0);
        run(7, 1'b1, 1'b0);
        run(2, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++)
            run(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        reset_mid_run();
        run(4, 1'b0, 1'b0);

        check("total_done", done_cnt, runs);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
